// File: rtl/vga_rx_decoder.sv
// VGA sink: recovers pixel_x/pixel_y from raw syncs, checks line/frame timing, streams active pixels.
// Pixels and probe hits appear 1 clk after their p_tick; no backpressure, the pixel stream cannot be stalled.
module vga_rx_decoder #(
  parameter int RGB_W     = 9,
  parameter int H_DISP    = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_DISP    = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit SYNC_POL  = 1'b1,
  parameter int ERR_LIMIT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             p_tick,
  input  logic             hsync,
  input  logic             vsync,
  input  logic [RGB_W-1:0] rgb,
  input  logic [9:0]       probe_x,
  input  logic [9:0]       probe_y,
  output logic [9:0]       pixel_x,
  output logic [9:0]       pixel_y,
  output logic             pix_valid,
  output logic [RGB_W-1:0] pix_rgb,
  output logic             locked,
  output logic             frame_start,
  output logic             line_err,
  output logic [7:0]       frame_cnt,
  output logic [RGB_W-1:0] probe_rgb,
  output logic             probe_done
);
  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int ERR_W   = $clog2(ERR_LIMIT + 1);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_LOAD   = 10'(H_DISP + H_FP);
  localparam logic [9:0] V_LOAD   = 10'(V_DISP + V_FP);
  localparam logic [9:0] H_ASSERT = 10'(H_DISP + H_FP - 1);
  localparam logic [9:0] H_RELEASE = 10'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_ACT    = 10'(H_DISP);
  localparam logic [9:0] V_ACT    = 10'(V_DISP);
  localparam logic [ERR_W-1:0] ERR_LAST = ERR_W'(ERR_LIMIT - 1);

  typedef enum logic [1:0] {HUNT, SYNC_H, SYNC_V, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_seen_q, err_seen_d;

  logic             hs_prev_q, vs_prev_q;
  logic [9:0]       h_cnt_q, h_cnt_d;
  logic [9:0]       v_cnt_q, v_cnt_d;
  logic [9:0]       probe_x_q, probe_y_q;
  logic [9:0]       pixel_x_q, pixel_y_q;
  logic [RGB_W-1:0] pix_rgb_q, probe_rgb_q;
  logic             pix_valid_q, probe_done_q, line_err_q, frame_start_q;
  logic [7:0]       frame_cnt_q;

  logic hs_rise, hs_fall, vs_rise, h_wrap, err_now, active, probe_hit;

  assign hs_rise = (hs_prev_q != SYNC_POL) && (hsync == SYNC_POL);
  assign hs_fall = (hs_prev_q == SYNC_POL) && (hsync != SYNC_POL);
  assign vs_rise = (vs_prev_q != SYNC_POL) && (vsync == SYNC_POL);
  assign h_wrap  = (h_cnt_q == H_LAST);

  // The _q counters hold the previous tick's position: the timing checks use them,
  // while the _d values are the position of the pixel arriving on this tick.
  assign err_now = (hs_rise && (h_cnt_q != H_ASSERT)) ||
                   (hs_fall && (h_cnt_q != H_RELEASE));

  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (hs_rise) begin
      h_cnt_d = H_LOAD;
    end else if (h_wrap) begin
      h_cnt_d = 10'd0;
      v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
    end
    if (vs_rise) begin
      v_cnt_d = V_LOAD;
    end
  end

  assign active    = (state_q == LOCKED) && (h_cnt_d < H_ACT) && (v_cnt_d < V_ACT);
  assign probe_hit = active && (h_cnt_d == probe_x_q) && (v_cnt_d == probe_y_q);

  always_comb begin
    state_d    = state_q;
    err_cnt_d  = err_cnt_q;
    err_seen_d = err_seen_q | err_now;
    case (state_q)
      HUNT: begin
        if (hs_rise) state_d = SYNC_H;
      end
      SYNC_H: begin
        if (vs_rise) begin
          state_d    = SYNC_V;
          err_seen_d = 1'b0;
        end
      end
      SYNC_V: begin
        if (vs_rise) begin
          err_seen_d = 1'b0;
          if (!(err_seen_q || err_now)) begin
            state_d   = LOCKED;
            err_cnt_d = '0;
          end
        end
      end
      LOCKED: begin
        // A line closes at each hsync assertion; its own edge error belongs to it.
        if (hs_rise) begin
          err_seen_d = 1'b0;
          if (err_seen_q || err_now) begin
            if (err_cnt_q == ERR_LAST) begin
              state_d   = HUNT;
              err_cnt_d = '0;
            end else begin
              err_cnt_d = err_cnt_q + 1'b1;
            end
          end else begin
            err_cnt_d = '0;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= HUNT;
      err_cnt_q  <= '0;
      err_seen_q <= 1'b0;
    end else if (p_tick) begin
      state_q    <= state_d;
      err_cnt_q  <= err_cnt_d;
      err_seen_q <= err_seen_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_prev_q     <= ~SYNC_POL;
      vs_prev_q     <= ~SYNC_POL;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      probe_x_q     <= '0;
      probe_y_q     <= '0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      pix_rgb_q     <= '0;
      probe_rgb_q   <= '0;
      pix_valid_q   <= 1'b0;
      probe_done_q  <= 1'b0;
      line_err_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      pix_valid_q   <= 1'b0;
      probe_done_q  <= 1'b0;
      line_err_q    <= 1'b0;
      frame_start_q <= 1'b0;
      if (p_tick) begin
        hs_prev_q  <= hsync;
        vs_prev_q  <= vsync;
        h_cnt_q    <= h_cnt_d;
        v_cnt_q    <= v_cnt_d;
        line_err_q <= err_now;
        if (vs_rise) begin
          frame_start_q <= 1'b1;
          probe_x_q     <= probe_x;
          probe_y_q     <= probe_y;
          if (state_q == LOCKED) frame_cnt_q <= frame_cnt_q + 8'd1;
        end
        if (active) begin
          pix_valid_q <= 1'b1;
          pixel_x_q   <= h_cnt_d;
          pixel_y_q   <= v_cnt_d;
          pix_rgb_q   <= rgb;
        end
        if (probe_hit) begin
          probe_done_q <= 1'b1;
          probe_rgb_q  <= rgb;
        end
      end
    end
  end

  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign pix_valid   = pix_valid_q;
  assign pix_rgb     = pix_rgb_q;
  assign locked      = (state_q == LOCKED);
  assign frame_start = frame_start_q;
  assign line_err    = line_err_q;
  assign frame_cnt   = frame_cnt_q;
  assign probe_rgb   = probe_rgb_q;
  assign probe_done  = probe_done_q;
endmodule

// File: tb/tb_vga_rx_decoder.sv
// Directed bench for vga_rx_decoder on a reduced 16x9 timing (8x4 active), p_tick every 2nd clk.
module tb_vga_rx_decoder;
  localparam int HS_ON  = 10;
  localparam int HS_END = 12;
  localparam int VS_ON  = 5;
  localparam int VS_END = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, p_tick, hsync, vsync;
  logic       hsync_n, vsync_n;
  logic [8:0] rgb;
  logic [9:0] probe_x, probe_y;

  logic [9:0] pixel_x, pixel_y;
  logic       pix_valid, locked, frame_start, line_err, probe_done;
  logic [8:0] pix_rgb, probe_rgb;
  logic [7:0] frame_cnt;

  logic [9:0] n_pixel_x, n_pixel_y;
  logic       n_pix_valid, n_locked, n_frame_start, n_line_err, n_probe_done;
  logic [8:0] n_pix_rgb, n_probe_rgb;
  logic [7:0] n_frame_cnt;

  assign hsync_n = ~hsync;
  assign vsync_n = ~vsync;

  vga_rx_decoder #(
    .RGB_W(9), .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_DISP(4), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b1), .ERR_LIMIT(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .p_tick(p_tick), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .probe_x(probe_x), .probe_y(probe_y), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pix_valid(pix_valid), .pix_rgb(pix_rgb), .locked(locked), .frame_start(frame_start),
    .line_err(line_err), .frame_cnt(frame_cnt), .probe_rgb(probe_rgb), .probe_done(probe_done)
  );

  vga_rx_decoder #(
    .RGB_W(9), .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_DISP(4), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b0), .ERR_LIMIT(4)
  ) dut_n (
    .clk(clk), .reset_n(reset_n), .p_tick(p_tick), .hsync(hsync_n), .vsync(vsync_n), .rgb(rgb),
    .probe_x(probe_x), .probe_y(probe_y), .pixel_x(n_pixel_x), .pixel_y(n_pixel_y),
    .pix_valid(n_pix_valid), .pix_rgb(n_pix_rgb), .locked(n_locked), .frame_start(n_frame_start),
    .line_err(n_line_err), .frame_cnt(n_frame_cnt), .probe_rgb(n_probe_rgb), .probe_done(n_probe_done)
  );

  logic outs_or, n_outs_or;
  assign outs_or = |{pixel_x, pixel_y, pix_valid, pix_rgb, locked, frame_start,
                     line_err, frame_cnt, probe_rgb, probe_done};
  assign n_outs_or = |{n_pixel_x, n_pixel_y, n_pix_valid, n_pix_rgb, n_locked, n_frame_start,
                       n_line_err, n_frame_cnt, n_probe_rgb, n_probe_done};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Source: a vga_sync-style transmitter; lines in [short_lo, short_hi) are one tick short.
  int src_h = 0, src_v = 0, cur_x = 0, cur_y = 0;
  int short_lo = 0, short_hi = 0;

  task automatic tick();
    cur_x  = src_h;
    cur_y  = src_v;
    hsync  = (src_h >= HS_ON) && (src_h <= HS_END);
    vsync  = (src_v >= VS_ON) && (src_v <= VS_END);
    rgb    = (src_h < 8 && src_v < 4) ? 9'(src_h ^ src_v) : 9'h0;
    p_tick = 1'b1;
    @(posedge clk); #1;
    p_tick = 1'b0;
    if (src_h == ((src_v >= short_lo && src_v < short_hi) ? 14 : 15)) begin
      src_h = 0;
      src_v = (src_v == 8) ? 0 : src_v + 1;
    end else begin
      src_h++;
    end
    @(posedge clk); #1;
  endtask

  int pv_cnt = 0, pv_bad = 0, pd_cnt = 0, le_cnt = 0, le_locked = 0, fs_cnt = 0;
  logic       after_err = 1'b0;
  logic [9:0] first_x = '0, first_y = '0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (pix_valid) begin
        pv_cnt++;
        if (pixel_x != 10'(cur_x) || pixel_y != 10'(cur_y) || pix_rgb != 9'(cur_x ^ cur_y))
          pv_bad++;
        if (after_err) begin
          first_x   = pixel_x;
          first_y   = pixel_y;
          after_err = 1'b0;
        end
      end
      if (probe_done) pd_cnt++;
      if (line_err) begin
        le_cnt++;
        if (locked) le_locked++;
        after_err = 1'b1;
      end
      if (frame_start) fs_cnt++;
    end
  end

  int d_pv, d_bad, d_pd, d_le, d_le_locked, d_fs;

  task automatic run_frame();
    int pv0 = pv_cnt, bad0 = pv_bad, pd0 = pd_cnt, le0 = le_cnt, ll0 = le_locked, fs0 = fs_cnt;
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(src_h == 0 && src_v == 0) && n < 400);
    d_pv = pv_cnt - pv0;  d_bad = pv_bad - bad0; d_pd = pd_cnt - pd0;
    d_le = le_cnt - le0;  d_le_locked = le_locked - ll0; d_fs = fs_cnt - fs0;
  endtask

  initial begin
    reset_n = 1'b0; p_tick = 1'b0; hsync = 1'b0; vsync = 1'b0; rgb = '0;
    probe_x = 10'd1; probe_y = 10'd2;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked", 32'(locked), 0);
    chk("rst_outs", 32'(outs_or), 0);
    chk("rst_outs_pol0", 32'(n_outs_or), 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Lock sequence: SYNC_V at the 1st vsync edge, LOCKED at the 2nd, first count at the 3rd.
    run_frame();
    chk("f1_locked", 32'(locked), 0);
    chk("f1_frame_start", d_fs, 1);
    chk("f1_no_pixels", d_pv, 0);
    chk("f1_locked_pol0", 32'(n_locked), 0);
    run_frame();
    chk("f2_locked", 32'(locked), 1);
    chk("f2_frame_cnt", 32'(frame_cnt), 0);
    chk("f2_line_err", d_le, 0);
    chk("f2_locked_pol0", 32'(n_locked), 1);
    run_frame();
    chk("f3_frame_cnt", 32'(frame_cnt), 1);
    chk("f3_frame_cnt_pol0", 32'(n_frame_cnt), 1);
    chk("f3_pix_count", d_pv, 32);
    chk("f3_pix_bad", d_bad, 0);
    chk("f3_probe_done", d_pd, 1);
    chk("f3_probe_rgb", 32'(probe_rgb), 3);

    // Probe moved before the frame's active area: takes effect only after this frame's vsync.
    probe_x = 10'd7; probe_y = 10'd3;
    run_frame();
    chk("f4_probe_deferred", 32'(probe_rgb), 3);
    chk("f4_probe_done", d_pd, 1);
    chk("f4_pix_count", d_pv, 32);
    chk("f4_pix_bad", d_bad, 0);
    run_frame();
    chk("f5_probe_corner", 32'(probe_rgb), 4);
    chk("f5_probe_done", d_pd, 1);

    // One short line: single error, lock held, next line starts at column 0.
    short_lo = 1; short_hi = 2;
    run_frame();
    short_hi = 0;
    chk("f6_line_err", d_le, 1);
    chk("f6_locked", 32'(locked), 1);
    chk("f6_resync_x", 32'(first_x), 0);
    chk("f6_resync_y", 32'(first_y), 3);
    run_frame();
    chk("f7_pix_count", d_pv, 32);
    chk("f7_pix_bad", d_bad, 0);
    chk("f7_line_err", d_le, 0);

    // Four short lines in a row: lock drops on the 4th error, then relocks in 2 clean frames.
    short_lo = 0; short_hi = 4;
    run_frame();
    short_hi = 0;
    chk("f8_line_err", d_le, 4);
    chk("f8_err_while_locked", d_le_locked, 3);
    chk("f8_locked", 32'(locked), 0);
    run_frame();
    chk("f9_locked", 32'(locked), 0);
    chk("f9_line_err", d_le, 0);
    run_frame();
    chk("f10_locked", 32'(locked), 1);
    chk("f10_frame_cnt", 32'(frame_cnt), 5);

    // Mid-line reset, then the normal lock sequence again.
    repeat (36) tick();
    chk("f11_pre_reset_locked", 32'(locked), 1);
    #3 reset_n = 1'b0;
    #1;
    chk("reset_async_outs", 32'(outs_or), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_held_outs", 32'(outs_or), 0);
    reset_n = 1'b1;
    run_frame();
    chk("f11_locked", 32'(locked), 0);
    run_frame();
    chk("f12_locked", 32'(locked), 1);
    chk("f12_frame_cnt", 32'(frame_cnt), 0);
    run_frame();
    chk("f13_frame_cnt", 32'(frame_cnt), 1);
    chk("f13_pix_count", d_pv, 32);
    chk("f13_pix_bad", d_bad, 0);
    chk("f13_probe_rgb", 32'(probe_rgb), 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
